// File: rtl/mvm_act_fifo.sv
// rtl/mvm_act_fifo.sv - shift/ReLU/saturate stage with vector tagging and result FIFO
// Results are activated on entry and stored as {last, ovf, data[7:0]}.
module mvm_act_fifo #(
  parameter int DEPTH   = 4,
  parameter int VEC_LEN = 3,
  parameter int SHIFT   = 0
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     s_valid,
  output logic                     s_ready,
  input  logic [15:0]              data_in,
  input  logic                     overflow_in,
  output logic                     m_valid,
  input  logic                     m_ready,
  output logic [7:0]               data_out,
  output logic                     last,
  output logic                     overflow,
  output logic                     err_sticky,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW     = $clog2(DEPTH);
  localparam int EW     = (VEC_LEN > 1) ? $clog2(VEC_LEN) : 1;
  localparam int LAST_I = VEC_LEN - 1;

  localparam logic [AW:0]   FULL_CNT = DEPTH[AW:0];
  localparam logic [AW:0]   CNT_ONE  = 1;
  localparam logic [AW-1:0] PTR_ONE  = 1;
  localparam logic [EW-1:0] ELEM_ONE = 1;
  localparam logic [EW-1:0] LAST_IDX = LAST_I[EW-1:0];

  logic [9:0]         mem [DEPTH];
  logic [AW-1:0]      wr_ptr;
  logic [AW-1:0]      rd_ptr;
  logic [EW-1:0]      elem_cnt;
  logic               wr;
  logic               rd;
  logic signed [15:0] shifted;
  logic [7:0]         act_data;
  logic               act_sat;
  logic               is_last;
  logic [9:0]         wr_entry;
  logic [9:0]         head;

  assign shifted = $signed(data_in) >>> SHIFT;

  // Negative results clamp to zero silently; only positive clipping counts as overflow.
  always_comb begin
    act_data = shifted[7:0];
    act_sat  = 1'b0;
    if (shifted[15]) begin
      act_data = 8'd0;
    end else if (shifted > 16'sd127) begin
      act_data = 8'd127;
      act_sat  = 1'b1;
    end
  end

  assign is_last  = (elem_cnt == LAST_IDX);
  assign wr_entry = {is_last, overflow_in | act_sat, act_data};

  // s_ready looks only at occupancy so a full FIFO never accepts on a same-cycle read.
  assign s_ready = (count < FULL_CNT);
  assign m_valid = (count != '0);
  assign wr      = s_valid & s_ready;
  assign rd      = m_valid & m_ready;

  assign head = m_valid ? mem[rd_ptr] : 10'd0;
  assign {last, overflow, data_out} = head;

  always_ff @(posedge clk) begin
    if (!reset && wr) begin
      mem[wr_ptr] <= wr_entry;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      elem_cnt   <= '0;
      count      <= '0;
      err_sticky <= 1'b0;
    end else begin
      if (wr) begin
        wr_ptr   <= wr_ptr + PTR_ONE;
        elem_cnt <= is_last ? '0 : elem_cnt + ELEM_ONE;
        if (wr_entry[8]) begin
          err_sticky <= 1'b1;
        end
      end
      if (rd) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      unique case ({wr, rd})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_mvm_act_fifo.sv
// tb/tb_mvm_act_fifo.sv - directed bench for mvm_act_fifo against a queue model
// Two instances (SHIFT=0 and SHIFT=4) share all inputs and are checked every cycle.
module tb_mvm_act_fifo;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        s_valid = 1'b0;
  logic [15:0] data_in = 16'd0;
  logic        overflow_in = 1'b0;
  logic        m_ready = 1'b0;

  logic       s_ready0, m_valid0, last0, overflow0, err0;
  logic [7:0] data_out0;
  logic [2:0] count0;
  logic       s_ready4, m_valid4, last4, overflow4, err4;
  logic [7:0] data_out4;
  logic [2:0] count4;

  int checks = 0;
  int errors = 0;
  bit started = 1'b0;

  logic [9:0] mq [2][64];
  int         mh [2];
  int         mt [2];
  int         melem [2];
  bit         merr [2];
  int         log_d [64];
  int         nlog = 0;

  mvm_act_fifo #(.DEPTH(4), .VEC_LEN(3), .SHIFT(0)) u0 (
    .clk(clk), .reset(reset), .s_valid(s_valid), .s_ready(s_ready0),
    .data_in(data_in), .overflow_in(overflow_in), .m_valid(m_valid0),
    .m_ready(m_ready), .data_out(data_out0), .last(last0),
    .overflow(overflow0), .err_sticky(err0), .count(count0)
  );

  mvm_act_fifo #(.DEPTH(4), .VEC_LEN(3), .SHIFT(4)) u4 (
    .clk(clk), .reset(reset), .s_valid(s_valid), .s_ready(s_ready4),
    .data_in(data_in), .overflow_in(overflow_in), .m_valid(m_valid4),
    .m_ready(m_ready), .data_out(data_out4), .last(last4),
    .overflow(overflow4), .err_sticky(err4), .count(count4)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual %0d required %0d", name, act, exp);
    end
  endtask

  function automatic logic [9:0] model_entry(input int sh, input logic [15:0] d,
                                             input logic oi, input bit lst);
    int t;
    int dv;
    bit sat;
    t = $signed(d);
    t = t >>> sh;
    sat = 1'b0;
    if (t < 0) dv = 0;
    else if (t > 127) begin dv = 127; sat = 1'b1; end
    else dv = t;
    return {lst, oi | sat, dv[7:0]};
  endfunction

  // Reference: each instance is a plain bounded queue of activated entries.
  always @(posedge clk) begin
    int  sz;
    bit  w;
    bit  r;
    logic [9:0] e;
    if (!reset && m_valid0 && m_ready && nlog < 64) begin
      log_d[nlog] = data_out0;
      nlog++;
    end
    for (int k = 0; k < 2; k++) begin
      if (reset) begin
        mh[k] = 0; mt[k] = 0; melem[k] = 0; merr[k] = 1'b0;
      end else begin
        sz = mt[k] - mh[k];
        w  = s_valid && (sz < 4);
        r  = (sz != 0) && m_ready;
        if (r) mh[k]++;
        if (w) begin
          e = model_entry((k == 0) ? 0 : 4, data_in, overflow_in, melem[k] == 2);
          mq[k][mt[k] % 64] = e;
          mt[k]++;
          melem[k] = (melem[k] + 1) % 3;
          if (e[8]) merr[k] = 1'b1;
        end
      end
    end
  end

  always @(negedge clk) begin
    int sz;
    logic [9:0] h;
    if (started) begin
      for (int k = 0; k < 2; k++) begin
        sz = mt[k] - mh[k];
        h  = (sz != 0) ? mq[k][mh[k] % 64] : 10'd0;
        if (k == 0) begin
          chk("m0_count", count0, sz);
          chk("m0_m_valid", m_valid0, sz != 0);
          chk("m0_s_ready", s_ready0, sz < 4);
          chk("m0_data_out", data_out0, h[7:0]);
          chk("m0_last", last0, h[9]);
          chk("m0_overflow", overflow0, h[8]);
          chk("m0_err_sticky", err0, merr[0]);
        end else begin
          chk("m4_count", count4, sz);
          chk("m4_m_valid", m_valid4, sz != 0);
          chk("m4_s_ready", s_ready4, sz < 4);
          chk("m4_data_out", data_out4, h[7:0]);
          chk("m4_last", last4, h[9]);
          chk("m4_overflow", overflow4, h[8]);
          chk("m4_err_sticky", err4, merr[1]);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [15:0] d, input logic oi);
    bit go;
    bit ok;
    ok = 1'b0;
    s_valid = 1'b1;
    data_in = d;
    overflow_in = oi;
    for (int i = 0; i < 40; i++) begin
      go = s_ready0;
      tick();
      if (go) begin
        ok = 1'b1;
        break;
      end
    end
    s_valid = 1'b0;
    overflow_in = 1'b0;
    if (!ok) chk("send_timeout", 0, 1);
  endtask

  task automatic drain();
    m_ready = 1'b1;
    for (int i = 0; i < 40 && count0 != 3'd0; i++) tick();
    chk("drain_empty", count0, 0);
  endtask

  initial begin
    int base;
    reset = 1'b1;
    tick();
    tick();
    started = 1'b1;
    chk("rst_count", count0, 0);
    chk("rst_m_valid", m_valid0, 0);
    chk("rst_s_ready", s_ready0, 1);
    chk("rst_err", err0, 0);
    chk("rst_data", data_out0, 0);
    reset = 1'b0;
    tick();

    // 5, -3, 200 with downstream always ready
    m_ready = 1'b1;
    send(16'd5, 1'b0);
    chk("t1_d0", data_out0, 5);
    chk("t1_l0", last0, 0);
    chk("t1_o0", overflow0, 0);
    send(16'hFFFD, 1'b0);
    chk("t1_d1", data_out0, 0);
    chk("t1_o1", overflow0, 0);
    chk("t1_err1", err0, 0);
    send(16'd200, 1'b0);
    chk("t1_d2", data_out0, 127);
    chk("t1_l2", last0, 1);
    chk("t1_o2", overflow0, 1);
    chk("t1_err2", err0, 1);
    drain();

    // back-pressure fills the FIFO, then six values emerge in order
    m_ready = 1'b0;
    base = nlog;
    for (int v = 11; v <= 14; v++) send(16'(v), 1'b0);
    s_valid = 1'b1;
    data_in = 16'd15;
    tick();
    tick();
    chk("t2_s_ready", s_ready0, 0);
    chk("t2_count", count0, 4);
    chk("t2_head_held", data_out0, 11);
    m_ready = 1'b1;
    send(16'd15, 1'b0);
    send(16'd16, 1'b0);
    drain();
    for (int i = 0; i < 6; i++) chk("t2_order", log_d[base + i], 11 + i);

    // steady state at occupancy 2
    m_ready = 1'b0;
    base = nlog;
    send(16'd20, 1'b0);
    send(16'd21, 1'b0);
    m_ready = 1'b1;
    s_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      data_in = 16'(30 + i);
      tick();
      chk("t3_count", count0, 2);
    end
    s_valid = 1'b0;
    drain();
    chk("t3_first", log_d[base], 20);
    chk("t3_second", log_d[base + 1], 21);
    for (int i = 0; i < 10; i++) chk("t3_order", log_d[base + 2 + i], 30 + i);

    // SHIFT=4 instance
    m_ready = 1'b1;
    send(16'h0800, 1'b0);
    chk("t4_d0", data_out4, 127);
    chk("t4_o0", overflow4, 1);
    chk("t4_s0_d0", data_out0, 127);
    send(16'hFFF0, 1'b0);
    chk("t4_d1", data_out4, 0);
    chk("t4_o1", overflow4, 0);
    send(16'h7FFF, 1'b0);
    chk("t4_d2", data_out4, 127);
    chk("t4_o2", overflow4, 1);
    drain();

    // upstream overflow flag on an in-range value
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("t5_err_clr", err0, 0);
    m_ready = 1'b1;
    send(16'd10, 1'b1);
    chk("t5_data", data_out0, 10);
    chk("t5_ovf", overflow0, 1);
    chk("t5_err", err0, 1);
    drain();

    // reset mid-vector with a handshake on the reset cycle
    m_ready = 1'b0;
    send(16'd40, 1'b0);
    send(16'd41, 1'b0);
    send(16'd42, 1'b0);
    chk("t6_count_pre", count0, 3);
    reset = 1'b1;
    s_valid = 1'b1;
    data_in = 16'd99;
    tick();
    reset = 1'b0;
    s_valid = 1'b0;
    chk("t6_m_valid", m_valid0, 0);
    chk("t6_count", count0, 0);
    chk("t6_s_ready", s_ready0, 1);
    send(16'd50, 1'b0);
    send(16'd51, 1'b0);
    send(16'd52, 1'b0);
    chk("t6_last0", last0, 0);
    m_ready = 1'b1;
    tick();
    chk("t6_last1", last0, 0);
    chk("t6_data1", data_out0, 51);
    tick();
    chk("t6_last2", last0, 1);
    chk("t6_data2", data_out0, 52);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
